comparator_arbiter: RTL and testbench
=====================================

Name: comparator_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single comparator_eq instance between R requesters in the etch-a-sketch design, for example cursor-vs-pixel and bound checks. Each requester presents an operand pair and holds a request line. The block grants one requester at a time, latches its operands, and runs the compare. It then returns a one-cycle ack with the registered equality result. It also keeps a saturating count of matches for debug.

Parameters:
N, 32, operand width passed to comparator_eq
R, 4, number of requesters (2..8)
CW, 16, width of the saturating match counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
req  input  R  per-requester request, held high until that requester's ack
a_in  input  R*N  packed operand A; requester i occupies bits [i*N +: N]
b_in  input  R*N  packed operand B, same packing as a_in
ack  output  R  one-hot, one-cycle pulse to the requester whose compare completed
result  output  1  equality result; valid only while ack is nonzero, else 0
busy  output  1  high in S_CMP and S_DONE
grant_id  output  $clog2(R)  index of the current or last granted requester
match_count  output  CW  saturating count of compares that returned equal

Behaviour:
- Reset (rst=0, async) sets the following:
  - state=S_IDLE
  - ack=0, result=0, busy=0
  - grant_id=0, rr_ptr=0, match_count=0
  - a_q=0, b_q=0
- FSM states are S_IDLE, S_CMP and S_DONE.
- S_IDLE:
  - If any req bit is high, pick the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... R-1, 0, ...).
  - Set grant_id to that index and latch a_q/b_q from that requester's slices.
  - Go to S_CMP.
  - If no req bit is high, stay in S_IDLE and hold grant_id.
- S_CMP:
  - comparator_eq(a_q, b_q) is combinational.
  - Register its output into res_q and go to S_DONE.
  - If res_q=1 and match_count is below all-ones, increment match_count; at all-ones it holds.
- S_DONE:
  - ack[grant_id]=1 and result=res_q for exactly this cycle.
  - Set rr_ptr to grant_id+1, wrapping R-1 to 0.
  - Go to S_IDLE.
- Latency: req sampled in S_IDLE at edge k; ack and result are high during the cycle after edge k+2. Throughput is one compare per 3 cycles.
- Operands are sampled only at the grant edge. Changing a_in/b_in afterwards has no effect on the result.
- Handshake: a requester must drop req in the cycle after its ack.
  - If req is still high at the next S_IDLE evaluation, it is a new request.
  - Because rr_ptr has moved past it, other pending requesters win first.
- Req dropped mid-operation: the compare still completes and the ack still pulses; the requester ignores it. No abort path.
- Simultaneous requests: only one grant per S_IDLE. Losers keep req high and are served in rotation, so worst-case wait is R grants.
- A new req arriving in S_CMP or S_DONE is not seen until the next S_IDLE.
- Reset asserted mid-operation: the in-flight compare is discarded, no ack is issued, and rr_ptr and match_count clear.
- Width rules:
  - The grant index is $clog2(R) bits; for R not a power of two the wrap is explicit, never natural overflow.
  - The a_in/b_in slices are exactly N bits.

Decomposition:
- Package comparator_arbiter_pkg holds the following:
  - typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} arb_state_t
  - localparam default widths
- Sub-module rr_picker (combinational).
  - Inputs: req[R], rr_ptr.
  - Outputs: found, idx.
  - It is reused by later shared-resource arbiters.
- The datapath instantiates the existing comparator_eq #(.N(N)) unchanged.

Test Plan:
- Reset, then req=4'b0001 with a_in[0]=b_in[0]=32'hDEAD_BEEF.
  - Required: ack=4'b0001 and result=1 two cycles after the grant edge.
  - Required: match_count=1, grant_id=0.
- req=4'b0010 with a_in[1]=32'h1, b_in[1]=32'h0.
  - Required: ack=4'b0010, result=0, match_count unchanged.
- req=4'b1111 held, with all pairs equal.
  - Required: acks in order 0001, 0010, 0100, 1000, then 0001 again, every 3 cycles.
  - Required: match_count increments by 1 each time.
- Requester 2 granted, a_in[2] changed in S_CMP from 5 to 6 with b_in[2]=5.
  - Required: result=1, proving operands were latched at grant.
- Assert rst=0 asynchronously during S_CMP.
  - Required: ack=0 and busy=0 immediately.
  - Required: no ack after rst=1.
  - Required: next grant starts search at index 0.
- CW=2 with 5 matching compares.
  - Required: match_count sequence 1, 2, 3, 3, 3 (saturates, no wrap).

Source files
------------

// File: rtl/comparator_arbiter_pkg.sv
// comparator_arbiter_pkg
//   Shared types and default widths for the comparator arbiter slice.
//   arb_state_t : sequencer states (idle -> compare -> done)
//   DEF_*       : default parameter values for operand width, requester
//                 count and match-counter width.
package comparator_arbiter_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} arb_state_t;

    localparam int DEF_N  = 32;
    localparam int DEF_R  = 4;
    localparam int DEF_CW = 16;

endpackage

// File: rtl/comparator_arbiter_if.sv
// comparator_arbiter_if
//   Bundles the requester-side bus of the comparator arbiter.
//   req/a_in/b_in : driven by requesters (master)
//   ack/result    : one-cycle completion pulse and equality result
//   busy/grant_id/match_count : status and debug outputs
//   Requester i owns a_in/b_in bits [i*N +: N].
interface comparator_arbiter_if #(
    parameter int N  = 32,
    parameter int R  = 4,
    parameter int CW = 16
);
    localparam int IW = $clog2(R);

    logic [R-1:0]   req;
    logic [R*N-1:0] a_in;
    logic [R*N-1:0] b_in;
    logic [R-1:0]   ack;
    logic           result;
    logic           busy;
    logic [IW-1:0]  grant_id;
    logic [CW-1:0]  match_count;

    modport master (
        output req, a_in, b_in,
        input  ack, result, busy, grant_id, match_count
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, result, busy, grant_id, match_count
    );
endinterface

// File: rtl/comparator_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin search: returns the first set request bit
//   at or above rr_ptr, wrapping from R-1 back to 0.
//   req    : request vector
//   rr_ptr : search start index (must be < R)
//   found  : any request set
//   idx    : selected index (equals rr_ptr when nothing is found)
module rr_picker #(
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    int p;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    // Wrap is done explicitly since R need not be a power of two.
    always_comb begin
        found = 1'b0;
        idx   = rr_ptr;
        p     = 0;
        for (int k = R - 1; k >= 0; k--) begin
            p = int'(rr_ptr) + k;
            if (p >= R) p = p - R;
            if (req[p]) begin
                found = 1'b1;
                idx   = IW'(p);
            end
        end
    end
endmodule

// File: rtl/comparator_eq.sv
// comparator_eq
//   Combinational N-bit equality compare.
//   a, b : operands
//   eq   : 1 when a == b
module comparator_eq #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);
    assign eq = (a == b);
endmodule

// File: rtl/comparator_arbiter.sv
// comparator_arbiter
//   Shares one comparator_eq between R requesters. Grants round-robin,
//   latches the winner's operands at the grant edge, compares, and returns
//   a one-cycle one-hot ack with the registered result. Keeps a saturating
//   count of equal compares.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of comparator_arbiter_if (req/a_in/b_in in,
//         ack/result/busy/grant_id/match_count out)
module comparator_arbiter
    import comparator_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int R  = DEF_R,
    parameter int CW = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    comparator_arbiter_if.slave  bus
);
    localparam int IW = $clog2(R);

    arb_state_t    state, nstate;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_id;
    logic [N-1:0]  a_q, b_q;
    logic          res_q;
    logic [R-1:0]  ack_q;
    logic          result_q;
    logic [CW-1:0] match_count;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          eq;

    rr_picker #(.R(R)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    comparator_eq #(.N(N)) u_eq (
        .a  (a_q),
        .b  (b_q),
        .eq (eq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (pick_found) nstate = S_CMP;
            S_CMP:   nstate = S_DONE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // ack/result are registered on the DONE->IDLE edge, so the pulse is
    // visible in the cycle after that edge and cleared on the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= 1'b0;
            ack_q       <= '0;
            result_q    <= 1'b0;
            match_count <= '0;
        end else begin
            ack_q    <= '0;
            result_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        a_q      <= bus.a_in[pick_idx*N +: N];
                        b_q      <= bus.b_in[pick_idx*N +: N];
                    end
                end
                S_CMP: begin
                    res_q <= eq;
                    if (eq && (match_count != {CW{1'b1}}))
                        match_count <= match_count + 1'b1;
                end
                S_DONE: begin
                    ack_q    <= R'(1) << grant_id;
                    result_q <= res_q;
                    rr_ptr   <= (grant_id == IW'(R - 1)) ? '0 : grant_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.result      = result_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.grant_id    = grant_id;
    assign bus.match_count = match_count;
endmodule

// File: tb/tb_comparator_arbiter.sv
module tb_comparator_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    comparator_arbiter_if #(.N(32), .R(4), .CW(16)) bus0 ();
    comparator_arbiter_if #(.N(32), .R(4), .CW(2))  bus1 ();

    assign bus1.req  = bus0.req;
    assign bus1.a_in = bus0.a_in;
    assign bus1.b_in = bus0.b_in;

    comparator_arbiter #(.N(32), .R(4), .CW(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    comparator_arbiter #(.N(32), .R(4), .CW(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus0.a_in[i*32 +: 32] = a;
        bus0.b_in[i*32 +: 32] = b;
    endtask

    logic [31:0] sat_exp [5];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sat_exp = '{1, 2, 3, 3, 3};
        rst       = 1'b0;
        bus0.req  = '0;
        bus0.a_in = '0;
        bus0.b_in = '0;
        #3;
        chk("rst_ack",    32'(bus0.ack), 0);
        chk("rst_result", 32'(bus0.result), 0);
        chk("rst_busy",   32'(bus0.busy), 0);
        chk("rst_grant",  32'(bus0.grant_id), 0);
        chk("rst_count",  32'(bus0.match_count), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick;

        // single equal compare on requester 0
        set_ops(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        bus0.req = 4'b0001;
        tick;
        chk("t1_busy_cmp", 32'(bus0.busy), 1);
        chk("t1_grant",    32'(bus0.grant_id), 0);
        chk("t1_ack_cmp",  32'(bus0.ack), 0);
        tick;
        chk("t1_ack_done", 32'(bus0.ack), 0);
        chk("t1_busy_done", 32'(bus0.busy), 1);
        tick;
        chk("t1_ack",    32'(bus0.ack), 32'b0001);
        chk("t1_result", 32'(bus0.result), 1);
        chk("t1_count",  32'(bus0.match_count), 1);
        chk("t1_busy",   32'(bus0.busy), 0);
        bus0.req = '0;
        tick;
        chk("t1_ack_pulse", 32'(bus0.ack), 0);
        chk("t1_res_clr",   32'(bus0.result), 0);

        // unequal compare on requester 1
        set_ops(1, 32'h1, 32'h0);
        bus0.req = 4'b0010;
        tick; tick; tick;
        chk("t2_ack",    32'(bus0.ack), 32'b0010);
        chk("t2_result", 32'(bus0.result), 0);
        chk("t2_count",  32'(bus0.match_count), 1);
        chk("t2_grant",  32'(bus0.grant_id), 1);
        bus0.req = '0;
        tick;

        // clean slate for rotation and saturation
        rst = 1'b0;
        #1;
        chk("r2_count", 32'(bus0.match_count), 0);
        @(negedge clk);
        rst = 1'b1;
        tick;

        // all four held, all pairs equal: rotation every 3 cycles
        for (int i = 0; i < 4; i++) set_ops(i, 32'h1111 * (i + 1), 32'h1111 * (i + 1));
        bus0.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            tick; tick; tick;
            chk($sformatf("t3_ack%0d", j),    32'(bus0.ack), 32'(1) << (j % 4));
            chk($sformatf("t3_res%0d", j),    32'(bus0.result), 1);
            chk($sformatf("t3_cnt%0d", j),    32'(bus0.match_count), 32'(j + 1));
            chk($sformatf("t3_sat%0d", j),    32'(bus1.match_count), sat_exp[j]);
        end
        bus0.req = '0;
        tick;

        // operands latched at grant: change a_in[2] during compare
        set_ops(2, 32'd5, 32'd5);
        bus0.req = 4'b0100;
        tick;
        chk("t4_grant", 32'(bus0.grant_id), 2);
        set_ops(2, 32'd6, 32'd5);
        tick; tick;
        chk("t4_ack",    32'(bus0.ack), 32'b0100);
        chk("t4_result", 32'(bus0.result), 1);
        bus0.req = '0;
        tick;

        // reset mid-compare; rr_ptr is 3 so requester 3 wins first
        set_ops(0, 32'd7, 32'd7);
        set_ops(3, 32'd9, 32'd9);
        bus0.req = 4'b1001;
        tick;
        chk("t5_grant_pre", 32'(bus0.grant_id), 3);
        chk("t5_busy_pre",  32'(bus0.busy), 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_ack",   32'(bus0.ack), 0);
        chk("t5_rst_busy",  32'(bus0.busy), 0);
        chk("t5_rst_count", 32'(bus0.match_count), 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("t5_grant_post", 32'(bus0.grant_id), 0);
        chk("t5_ack_a",      32'(bus0.ack), 0);
        tick;
        chk("t5_ack_b",      32'(bus0.ack), 0);
        tick;
        chk("t5_ack",        32'(bus0.ack), 32'b0001);
        chk("t5_result",     32'(bus0.result), 1);
        chk("t5_count",      32'(bus0.match_count), 1);
        bus0.req = '0;
        tick;
        chk("t5_ack_clr",    32'(bus0.ack), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
